// File: rtl/jt6295_pkg.sv
// Shared constants for the JT6295 output stage.
//   SW_DEF     : default sample width
//   GAIN_UNITY : 4.4 fixed-point gain of 1.0
//   GMAX/GMIN  : signed clip limits for SW_DEF-bit samples
//   clip_max/clip_min : signed limits for an arbitrary width
package jt6295_pkg;

    localparam int unsigned SW_DEF     = 14;
    localparam logic [7:0]  GAIN_UNITY = 8'h10;
    localparam int          GMAX       = 2**(SW_DEF-1) - 1;
    localparam int          GMIN       = -(2**(SW_DEF-1));

    function automatic int clip_max(input int w);
        return 2**(w-1) - 1;
    endfunction

    function automatic int clip_min(input int w);
        return -(2**(w-1));
    endfunction

endpackage

// File: rtl/jt6295_clip.sv
// Combinational signed saturator.
//   din  : signed IW-bit value
//   dout : din clamped to the signed OW-bit range
//   sat  : high when din was outside that range
module jt6295_clip
    import jt6295_pkg::*;
#(
    parameter int IW = 19,
    parameter int OW = 14
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout,
    output logic                 sat
);

    localparam logic signed [IW-1:0] HI = IW'(clip_max(OW));
    localparam logic signed [IW-1:0] LO = IW'(clip_min(OW));

    always_comb begin
        dout = din[OW-1:0];
        sat  = 1'b0;
        if (din > HI) begin
            dout = HI[OW-1:0];
            sat  = 1'b1;
        end else if (din < LO) begin
            dout = LO[OW-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/jt6295_interp.sv
// Linear sample interpolator with 4.4 gain and symmetric clipping.
//   clk, rst : clock, synchronous active-high reset
//   cen_in   : accept snd_in and restart the ramp from the previous sample
//   cen_out  : advance the ramp one step (2^STEPW steps per input sample)
//   snd_in   : signed input sample
//   gain     : unsigned 4.4 gain, 0x10 = unity
//   snd_out  : interpolated, gained, clipped sample (1 clk after acc/gain)
//   sat      : high while snd_out is a clipped value
module jt6295_interp
    import jt6295_pkg::*;
#(
    parameter int STEPW = 2,
    parameter int SW    = SW_DEF
) (
    input  logic                 rst,
    input  logic                 clk,
    input  logic                 cen_in,
    input  logic                 cen_out,
    input  logic signed [SW-1:0] snd_in,
    input  logic [7:0]           gain,
    output logic signed [SW-1:0] snd_out,
    output logic                 sat
);

    localparam int AW    = SW + STEPW + 1;
    localparam int PW    = STEPW + 1;
    localparam int NSTEP = 2**STEPW;

    logic signed [SW-1:0] cur;
    logic signed [SW-1:0] base;
    logic signed [SW:0]   delta;
    logic [PW-1:0]        phase;
    logic signed [AW-1:0] acc;

    logic signed [SW-1:0] interp;
    logic signed [SW+8:0] prod;
    logic signed [SW+4:0] gsh;
    logic signed [SW-1:0] clip_out;
    logic                 clip_sat;
    logic signed [AW-1:0] acc_ref;

    // acc holds interp in SW.STEPW fixed point; the shift floors toward -inf
    assign interp = SW'(acc >>> STEPW);
    assign prod   = (SW+9)'(interp) * (SW+9)'($signed({1'b0, gain}));
    assign gsh    = (SW+5)'(prod >>> 4);

    jt6295_clip #(
        .IW (SW+5),
        .OW (SW)
    ) u_clip (
        .din  (gsh),
        .dout (clip_out),
        .sat  (clip_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= '0;
            base    <= '0;
            delta   <= '0;
            phase   <= '0;
            acc     <= '0;
            snd_out <= '0;
            sat     <= 1'b0;
        end else begin
            if (cen_in) begin
                // restart from the previously accepted sample
                base  <= cur;
                cur   <= snd_in;
                delta <= (SW+1)'(snd_in) - (SW+1)'(cur);
                phase <= '0;
                acc   <= AW'(cur) <<< STEPW;
            end else if (cen_out && phase < PW'(NSTEP)) begin
                acc   <= acc + AW'(delta);
                phase <= phase + 1'b1;
            end
            if (gain == 8'd0) begin
                snd_out <= '0;
                sat     <= 1'b0;
            end else begin
                snd_out <= clip_out;
                sat     <= clip_sat;
            end
        end
    end

    // acc must always equal base<<STEPW + delta*phase (never wraps)
    assign acc_ref = (AW'(base) <<< STEPW) + AW'(delta) * AW'($signed({1'b0, phase}));

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (acc == acc_ref);
        end
    end

endmodule

// File: tb/tb_jt6295_interp.sv
// Bench for jt6295_interp: constant vector table, hand sequences for
// gain latency and reset mid-ramp, then random strobes against a model.
module tb_jt6295_interp;
    import jt6295_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               cen_in;
    logic               cen_out;
    logic signed [13:0] snd_in;
    logic [7:0]         gain;
    logic signed [13:0] snd_out;
    logic               sat;

    int checks   = 0;
    int failures = 0;

    jt6295_interp #(
        .STEPW (2),
        .SW    (14)
    ) dut (
        .rst     (rst),
        .clk     (clk),
        .cen_in  (cen_in),
        .cen_out (cen_out),
        .snd_in  (snd_in),
        .gain    (gain),
        .snd_out (snd_out),
        .sat     (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         ci;
        bit         co;
        int         din;
        logic [7:0] g;
        int         eo;
        bit         es;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit ci, bit co, int din, logic [7:0] g, int eo, bit es);
        vec_t v;
        v.ci = ci; v.co = co; v.din = din; v.g = g; v.eo = eo; v.es = es;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one strobe cycle then one idle cycle so snd_out reflects the update
    task automatic apply(input bit ci, input bit co, input int din, input logic [7:0] g);
        cen_in  = ci;
        cen_out = co;
        snd_in  = 14'(din);
        gain    = g;
        tick();
        cen_in  = 1'b0;
        cen_out = 1'b0;
        tick();
    endtask

    // Reference model: interp = base + floor(delta*phase/4)
    int m_cur, m_base, m_delta, m_phase;

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q -= 1;
        return q;
    endfunction

    function automatic void model_out(input int g, output int o, output int s);
        int iv, gv;
        iv = m_base + fdiv(m_delta * m_phase, 4);
        gv = fdiv(iv * g, 16);
        if (g == 0) begin o = 0; s = 0; end
        else if (gv > GMAX) begin o = GMAX; s = 1; end
        else if (gv < GMIN) begin o = GMIN; s = 1; end
        else begin o = gv; s = 0; end
    endfunction

    task automatic rcycle(input bit ci, input bit co, input int din, input int g);
        int eo, es;
        cen_in  = ci;
        cen_out = co;
        snd_in  = 14'(din);
        gain    = 8'(g);
        model_out(g, eo, es);
        @(posedge clk);
        if (ci) begin
            m_base  = m_cur;
            m_delta = din - m_cur;
            m_cur   = din;
            m_phase = 0;
        end else if (co && m_phase < 4) begin
            m_phase++;
        end
        #1;
        check("rand_out", int'(snd_out), eo);
        check("rand_sat", int'(sat), es);
    endtask

    initial begin
        int g;
        rst = 1'b1; cen_in = 1'b0; cen_out = 1'b0; snd_in = '0; gain = GAIN_UNITY;
        tick();
        check("reset_out", int'(snd_out), 0);
        check("reset_sat", int'(sat), 0);
        check("reset_acc", int'(dut.acc), 0);
        check("reset_phase", int'(dut.phase), 0);
        rst = 1'b0;

        // ramp up
        add(1, 0, 400, 8'h10, 0, 0);
        add(0, 1, 0, 8'h10, 100, 0);
        add(0, 1, 0, 8'h10, 200, 0);
        add(0, 1, 0, 8'h10, 300, 0);
        add(0, 1, 0, 8'h10, 400, 0);
        add(0, 1, 0, 8'h10, 400, 0);
        // ramp down
        add(1, 0, -400, 8'h10, 400, 0);
        add(0, 1, 0, 8'h10, 200, 0);
        add(0, 1, 0, 8'h10, 0, 0);
        add(0, 1, 0, 8'h10, -200, 0);
        add(0, 1, 0, 8'h10, -400, 0);
        // settle to 0, then floor behaviour toward -1
        add(1, 0, 0, 8'h10, -400, 0);
        add(0, 1, 0, 8'h10, -300, 0);
        add(0, 1, 0, 8'h10, -200, 0);
        add(0, 1, 0, 8'h10, -100, 0);
        add(0, 1, 0, 8'h10, 0, 0);
        add(1, 0, -1, 8'h10, 0, 0);
        add(0, 1, 0, 8'h10, -1, 0);
        add(0, 1, 0, 8'h10, -1, 0);
        add(0, 1, 0, 8'h10, -1, 0);
        add(0, 1, 0, 8'h10, -1, 0);
        // gain and saturation
        add(1, 0, 1000, 8'h10, -1, 0);
        add(0, 1, 0, 8'h10, 249, 0);
        add(0, 1, 0, 8'h10, 499, 0);
        add(0, 1, 0, 8'h10, 749, 0);
        add(0, 1, 0, 8'h10, 1000, 0);
        add(0, 0, 0, 8'h08, 500, 0);
        add(0, 0, 0, 8'hFF, 8191, 1);
        add(1, 0, -1000, 8'hFF, 8191, 1);
        add(0, 1, 0, 8'hFF, 7968, 0);
        add(0, 1, 0, 8'hFF, 0, 0);
        add(0, 1, 0, 8'hFF, -7969, 0);
        add(0, 1, 0, 8'hFF, -8192, 1);
        add(0, 0, 0, 8'h00, 0, 0);
        add(0, 0, 0, 8'h10, -1000, 0);
        // strobe collision
        add(1, 0, 0, 8'h10, -1000, 0);
        add(0, 1, 0, 8'h10, -750, 0);
        add(0, 1, 0, 8'h10, -500, 0);
        add(0, 1, 0, 8'h10, -250, 0);
        add(0, 1, 0, 8'h10, 0, 0);
        add(1, 1, 800, 8'h10, 0, 0);
        add(0, 1, 0, 8'h10, 200, 0);
        // full-scale swing
        add(1, 0, -8192, 8'h10, 800, 0);
        add(0, 1, 0, 8'h10, -1448, 0);
        add(0, 1, 0, 8'h10, -3696, 0);
        add(0, 1, 0, 8'h10, -5944, 0);
        add(0, 1, 0, 8'h10, -8192, 0);
        add(1, 0, 8191, 8'h10, -8192, 0);
        add(0, 1, 0, 8'h10, -4097, 0);
        add(0, 1, 0, 8'h10, -1, 0);
        add(0, 1, 0, 8'h10, 4095, 0);
        add(0, 1, 0, 8'h10, 8191, 0);
        add(0, 1, 0, 8'h10, 8191, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].ci, vecs[i].co, vecs[i].din, vecs[i].g);
            check($sformatf("vec%0d_out", i), int'(snd_out), vecs[i].eo);
            check($sformatf("vec%0d_sat", i), int'(sat), vecs[i].es);
        end

        // gain change visible exactly one clk later, no strobes
        gain = 8'h08;
        tick();
        check("gain_lat_out", int'(snd_out), 4095);
        check("gain_lat_sat", int'(sat), 0);
        gain = 8'h20;
        tick();
        check("gain_lat2_out", int'(snd_out), 8191);
        check("gain_lat2_sat", int'(sat), 1);
        gain = 8'h10;

        // reset mid-ramp
        apply(1, 0, 0, 8'h10);
        for (int i = 0; i < 4; i++) apply(0, 1, 0, 8'h10);
        apply(1, 0, 400, 8'h10);
        apply(0, 1, 0, 8'h10);
        apply(0, 1, 0, 8'h10);
        check("mid_ramp_out", int'(snd_out), 200);
        rst = 1'b1;
        tick();
        check("rst_mid_out", int'(snd_out), 0);
        check("rst_mid_sat", int'(sat), 0);
        check("rst_mid_acc", int'(dut.acc), 0);
        check("rst_mid_phase", int'(dut.phase), 0);
        check("rst_mid_cur", int'(dut.cur), 0);
        check("rst_mid_delta", int'(dut.delta), 0);
        rst = 1'b0;
        apply(1, 0, 400, 8'h10);
        check("rerun0", int'(snd_out), 0);
        for (int i = 1; i <= 4; i++) begin
            apply(0, 1, 0, 8'h10);
            check($sformatf("rerun%0d", i), int'(snd_out), 100 * i);
        end

        // random strobes against the model, from a clean reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_cur = 0; m_base = 0; m_delta = 0; m_phase = 0;
        g = 16;
        for (int i = 0; i < 3000; i++) begin
            int din;
            bit ci, co;
            if ($urandom_range(0, 15) == 0)
                g = ($urandom_range(0, 1) == 0) ? 16 : int'($urandom_range(0, 255));
            case ($urandom_range(0, 7))
                0:       din = -8192;
                1:       din = 8191;
                default: din = int'($urandom_range(0, 16383)) - 8192;
            endcase
            ci = ($urandom_range(0, 7) == 0);
            co = ($urandom_range(0, 1) == 0);
            rcycle(ci, co, din, g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
